avr_cpu_register_file: RTL and testbench
========================================

Name: avr_cpu_register_file

Overview:
- Parametrised successor of the AVR general-purpose register file.
- Provides two synchronous read ports with optional Z-indirect addressing.
- Write path supports byte writes, even-aligned word writes (MOVW/ADIW/MUL results) and X/Y/Z pointer post-increment/pre-decrement for LD/ST addressing.
- Asynchronous active-low reset clears the bank. Sits between the decoder and the ALU/LSU in the CPU core.

Parameters:
- NUM_REGS, 32, number of registers; power of two, >= 8; AW = clog2(NUM_REGS) is a derived localparam.
- DATA_W, 8, register width in bits; pointers are 2*DATA_W wide.
- PTR_BASE, NUM_REGS-6, index of XL; X={r[B+1],r[B]}, Y={r[B+3],r[B+2]}, Z={r[B+5],r[B+4]}.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r_addr  in  AW  read port R address
- d_addr  in  AW  read port D address and write address
- z_r_addr  in  1  port R uses Z[AW-1:0] instead of r_addr
- z_d_addr  in  1  port D uses Z[AW-1:0] instead of d_addr (read only; the write address is always d_addr)
- r_out  out  DATA_W  registered port R data
- d_out  out  DATA_W  registered port D data
- in  in  DATA_W  write data (low byte for word writes)
- in_hi  in  DATA_W  high byte for word writes
- write  in  1  byte write of in to d_addr
- write_word  in  1  word write: in to d_addr, in_hi to d_addr+1; d_addr[0] is ignored (treated as 0)
- ptr_sel  in  2  0=X, 1=Y, 2=Z, 3=reserved (no pointer operation)
- ptr_op  in  2  0=none, 1=post-inc, 2=pre-dec, 3=reserved (no operation)
- ptr_out  out  2*DATA_W  effective address: selected pointer for op 0/1, pointer-1 for op 2; combinational
- x, y, z  out  2*DATA_W  current pointer values; combinational from bank

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0; r_out = d_out = 0; hence x = y = z = 0. Released synchronously at the next clk edge.
- Reads: 1-cycle latency. r_out/d_out at edge N+1 carry the register value addressed at edge N, after that edge's writes are applied (write-through bypass).
- Indirect read: the Z value used is the pre-edge Z; the bypass then applies to the selected address.
- Byte write: if write=1, the register at d_addr takes in at the edge.
- Word write: if write_word=1, the registers at {d_addr[AW-1:1],0} and {d_addr[AW-1:1],1} take in and in_hi. If write and write_word are both set, write_word wins.
- Pointer op:
  - post-inc: selected pointer <= pointer+1; ptr_out = old value.
  - pre-dec: selected pointer <= pointer-1; ptr_out = pointer-1.
  - Arithmetic is modulo 2^(2*DATA_W): 0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF.
- Collision: if a byte or word write hits either byte of the selected pointer in the same cycle, the data write wins for the bytes it touches. The pointer update is then discarded entirely (no partial update).
- Reserved ptr_sel/ptr_op: no pointer update; ptr_out = X for ptr_sel=3.
- Registers not written and not pointer-updated hold their value.

Decomposition:
- Shared package avr_cpu_pkg holds:
  - PTR_NONE/PTR_INC/PTR_DEC encodings
  - PTR_X/PTR_Y/PTR_Z select encodings
  - a DATA_W default constant
- Sub-module avr_ptr_incdec (2*DATA_W adder, ±1 with wrap; outputs the next pointer and the effective address). One instance is shared across X/Y/Z via ptr_sel mux.

Test Plan:
- Reset mid-operation: write r5=0xA5, assert rst_n=0 between edges -> r_out, d_out, x, y, z read 0 immediately; read r5 after release -> 0x00.
- Byte write with bypass: write=1, d_addr=3, in=0x5C, r_addr=3 in the same cycle -> r_out=0x5C one cycle later.
- Word write: write_word=1, d_addr=25 (odd), in=0x34, in_hi=0x12 -> r24=0x34, r25=0x12.
- Word write to the X pair: write_word=1, d_addr=26, in=0x34, in_hi=0x12 -> x=0x1234.
- Pointer wrap: Y=0xFFFF, post-inc -> ptr_out=0xFFFF, then y=0x0000. Pre-dec on Y=0x0000 -> ptr_out=0xFFFF, y=0xFFFF.
- Collision: Z=0x0100, ptr_sel=Z, ptr_op=inc, write r31=0x80 in the same cycle -> z=0x8000 (write wins, no increment).
- Indirect read: Z=0x0007, r7=0x42, z_r_addr=1 -> r_out=0x42 after 1 cycle. With a simultaneous write of r7=0x99 -> r_out=0x99.

Source files
------------

// File: rtl/avr_cpu_pkg.sv
// avr_cpu_pkg: shared encodings for the AVR register file and pointer unit
// Holds the pointer select/operation encodings and the default register width.
package avr_cpu_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {PTR_X = 2'd0, PTR_Y = 2'd1, PTR_Z = 2'd2, PTR_SEL_RSVD = 2'd3} ptr_sel_e;
  typedef enum logic [1:0] {PTR_NONE = 2'd0, PTR_INC = 2'd1, PTR_DEC = 2'd2, PTR_OP_RSVD = 2'd3} ptr_op_e;
endpackage

// File: rtl/avr_ptr_incdec.sv
// avr_ptr_incdec: +/-1 pointer adder with wrap, giving next pointer and effective address
// ptr: current pointer; op: ptr_op_e encoding
// nxt: pointer after the operation; eff: effective address (pre-dec value or old value)
module avr_ptr_incdec
  import avr_cpu_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic [PW-1:0] ptr,
  input  logic [1:0]    op,
  output logic [PW-1:0] nxt,
  output logic [PW-1:0] eff
);
  logic [PW-1:0] dec;
  assign dec = ptr - PW'(1);
  assign nxt = op == PTR_INC ? ptr + PW'(1) : op == PTR_DEC ? dec : ptr;
  assign eff = op == PTR_DEC ? dec : ptr;
endmodule

// File: rtl/avr_cpu_register_file.sv
// avr_cpu_register_file: AVR general-purpose register bank with two registered read ports
// clk/rst_n: clock and async active-low reset
// r_addr/d_addr, z_r_addr/z_d_addr: read addresses, optionally Z-indirect; d_addr is also the write address
// in/in_hi, write/write_word: byte or even-aligned word write data and strobes
// ptr_sel/ptr_op: X/Y/Z post-inc or pre-dec; ptr_out is the effective address
// r_out/d_out: registered read data; x/y/z: current pointer values
module avr_cpu_register_file
  import avr_cpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PTR_BASE = NUM_REGS - 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] r_addr,
  input  logic [$clog2(NUM_REGS)-1:0] d_addr,
  input  logic                        z_r_addr,
  input  logic                        z_d_addr,
  output logic [DATA_W-1:0]           r_out,
  output logic [DATA_W-1:0]           d_out,
  input  logic [DATA_W-1:0]           in,
  input  logic [DATA_W-1:0]           in_hi,
  input  logic                        write,
  input  logic                        write_word,
  input  logic [1:0]                  ptr_sel,
  input  logic [1:0]                  ptr_op,
  output logic [2*DATA_W-1:0]         ptr_out,
  output logic [2*DATA_W-1:0]         x,
  output logic [2*DATA_W-1:0]         y,
  output logic [2*DATA_W-1:0]         z
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int PW = 2 * DATA_W;
  localparam logic [AW-1:0] PB = AW'(PTR_BASE);
  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [DATA_W-1:0] nxt [NUM_REGS];
  logic [PW-1:0] sel_ptr, nxt_ptr;
  logic [AW-1:0] p_lo, p_hi, w_lo, w_hi, r_sel, d_sel;
  logic [1:0] op_eff;
  logic w_any, hit, ptr_upd;
  assign x = {bank[PTR_BASE+1], bank[PTR_BASE]};
  assign y = {bank[PTR_BASE+3], bank[PTR_BASE+2]};
  assign z = {bank[PTR_BASE+5], bank[PTR_BASE+4]};
  assign sel_ptr = ptr_sel == PTR_Y ? y : ptr_sel == PTR_Z ? z : x;
  // reserved select suppresses the operation so ptr_out shows plain X
  assign op_eff = ptr_sel == PTR_SEL_RSVD ? PTR_NONE : ptr_op;
  avr_ptr_incdec #(.PW(PW)) u_incdec (
    .ptr(sel_ptr),
    .op (op_eff),
    .nxt(nxt_ptr),
    .eff(ptr_out)
  );
  assign p_lo  = PB + AW'({ptr_sel, 1'b0});
  assign p_hi  = p_lo + AW'(1);
  assign w_any = write | write_word;
  assign w_lo  = write_word ? {d_addr[AW-1:1], 1'b0} : d_addr;
  assign w_hi  = {d_addr[AW-1:1], 1'b1};
  // any data write touching the selected pointer cancels the whole pointer update
  assign hit = (w_any && (w_lo == p_lo || w_lo == p_hi)) ||
               (write_word && (w_hi == p_lo || w_hi == p_hi));
  assign ptr_upd = (op_eff == PTR_INC || op_eff == PTR_DEC) && !hit;
  always_comb begin
    nxt = bank;
    if (ptr_upd) begin
      nxt[p_lo] = nxt_ptr[DATA_W-1:0];
      nxt[p_hi] = nxt_ptr[PW-1:DATA_W];
    end
    if (w_any) nxt[w_lo] = in;
    if (write_word) nxt[w_hi] = in_hi;
  end
  assign r_sel = z_r_addr ? z[AW-1:0] : r_addr;
  assign d_sel = z_d_addr ? z[AW-1:0] : d_addr;
  // reads sample the post-write bank, giving write-through bypass
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bank  <= '{default: '0};
      r_out <= '0;
      d_out <= '0;
    end else begin
      bank  <= nxt;
      r_out <= nxt[r_sel];
      d_out <= nxt[d_sel];
    end
endmodule

// File: tb/tb_avr_cpu_register_file.sv
// tb_avr_cpu_register_file: directed bench with a behavioural register-file model
module tb_avr_cpu_register_file;
  logic clk = 0, rst_n = 0;
  logic [4:0] r_addr = 0, d_addr = 0;
  logic z_r_addr = 0, z_d_addr = 0, write = 0, write_word = 0;
  logic [7:0] din = 0, din_hi = 0, r_out, d_out;
  logic [1:0] ptr_sel = 0, ptr_op = 0;
  logic [15:0] ptr_out, x, y, z;
  logic [7:0] m [32];
  logic [7:0] mr = 0, md = 0;
  bit run = 0;
  int checks = 0, errors = 0;
  avr_cpu_register_file dut (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .d_addr(d_addr),
    .z_r_addr(z_r_addr), .z_d_addr(z_d_addr), .r_out(r_out), .d_out(d_out),
    .in(din), .in_hi(din_hi), .write(write), .write_word(write_word),
    .ptr_sel(ptr_sel), .ptr_op(ptr_op), .ptr_out(ptr_out), .x(x), .y(y), .z(z)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mp(int s);
    return {m[27 + 2 * s], m[26 + 2 * s]};
  endfunction
  function automatic logic [15:0] exp_ptr();
    logic [15:0] p;
    if (ptr_sel == 3) return mp(0);
    p = mp(int'(ptr_sel));
    return ptr_op == 2 ? p - 16'd1 : p;
  endfunction
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < 32; i++) m[i] = 0;
    mr = 0;
    md = 0;
  endtask
  // the model treats a pointer as a 16-bit number and a write as a set of touched indices
  task automatic model_edge();
    logic [7:0] n [32];
    logic [15:0] zold, p;
    int b, wa[$];
    bit coll;
    n = m;
    zold = mp(2);
    if (write_word) begin
      wa.push_back(int'(d_addr) & ~1);
      wa.push_back((int'(d_addr) & ~1) + 1);
    end else if (write) wa.push_back(int'(d_addr));
    if (ptr_sel != 3 && (ptr_op == 1 || ptr_op == 2)) begin
      b = 26 + 2 * int'(ptr_sel);
      coll = 0;
      foreach (wa[i]) if (wa[i] == b || wa[i] == b + 1) coll = 1;
      if (!coll) begin
        p = ptr_op == 1 ? mp(int'(ptr_sel)) + 16'd1 : mp(int'(ptr_sel)) - 16'd1;
        n[b] = p[7:0];
        n[b + 1] = p[15:8];
      end
    end
    if (write_word) begin
      n[wa[0]] = din;
      n[wa[1]] = din_hi;
    end else if (write) n[wa[0]] = din;
    m = n;
    mr = m[z_r_addr ? zold[4:0] : r_addr];
    md = m[z_d_addr ? zold[4:0] : d_addr];
  endtask
  always @(negedge clk)
    if (run && rst_n) begin
      chk("r_out", {8'h0, r_out}, {8'h0, mr});
      chk("d_out", {8'h0, d_out}, {8'h0, md});
      chk("x", x, mp(0));
      chk("y", y, mp(1));
      chk("z", z, mp(2));
      chk("ptr_out", ptr_out, exp_ptr());
    end
  task automatic drive(int ra, int da, int zr, int zd, int d, int dh, int w, int ww, int ps, int po);
    #1;
    r_addr = 5'(ra); d_addr = 5'(da); z_r_addr = 1'(zr); z_d_addr = 1'(zd);
    din = 8'(d); din_hi = 8'(dh); write = 1'(w); write_word = 1'(ww);
    ptr_sel = 2'(ps); ptr_op = 2'(po);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic cyc(int ra, int da, int zr, int zd, int d, int dh, int w, int ww, int ps, int po);
    drive(ra, da, zr, zd, d, dh, w, ww, ps, po);
    tick();
  endtask
  task automatic word(int da, int lo, int hi);
    cyc(0, 0, 0, 0, lo, hi, 0, 1, 0, 0);
    cyc(0, da, 0, 0, lo, hi, 0, 1, 3, 0);
  endtask
  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    run = 1;
    chk("reset r_out", {8'h0, r_out}, 16'h0);
    chk("reset x", x, 16'h0);
    chk("reset z", z, 16'h0);
    @(negedge clk);
    cyc(5, 5, 0, 0, 8'hA5, 0, 1, 0, 0, 0);
    chk("r5 written", {8'h0, r_out}, 16'h00A5);
    #3 rst_n = 0;
    clear_model();
    #1;
    chk("async rst r_out", {8'h0, r_out}, 16'h0);
    chk("async rst d_out", {8'h0, d_out}, 16'h0);
    chk("async rst xyz", x | y | z, 16'h0);
    @(negedge clk);
    #1 rst_n = 1;
    cyc(5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r5 after reset", {8'h0, r_out}, 16'h0);
    cyc(3, 3, 0, 0, 8'h5C, 0, 1, 0, 0, 0);
    chk("byte bypass", {8'h0, r_out}, 16'h005C);
    cyc(0, 25, 0, 0, 8'h34, 8'h12, 0, 1, 0, 0);
    cyc(24, 25, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("word r24", {8'h0, r_out}, 16'h0034);
    chk("word r25", {8'h0, d_out}, 16'h0012);
    cyc(0, 26, 0, 0, 8'h34, 8'h12, 1, 1, 0, 0);
    chk("word x", x, 16'h1234);
    cyc(0, 28, 0, 0, 8'hFF, 8'hFF, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("y inc ptr_out", ptr_out, 16'hFFFF);
    tick();
    chk("y wrap up", y, 16'h0000);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    #1 chk("y dec ptr_out", ptr_out, 16'hFFFF);
    tick();
    chk("y wrap down", y, 16'hFFFF);
    cyc(0, 30, 0, 0, 8'h00, 8'h01, 0, 1, 0, 0);
    cyc(0, 31, 0, 0, 8'h80, 0, 1, 0, 2, 1);
    chk("collision z", z, 16'h8000);
    cyc(0, 30, 0, 0, 8'h07, 8'h00, 0, 1, 0, 0);
    cyc(0, 7, 0, 0, 8'h42, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("indirect r", {8'h0, r_out}, 16'h0042);
    cyc(0, 7, 1, 0, 8'h99, 0, 1, 0, 0, 0);
    chk("indirect bypass", {8'h0, r_out}, 16'h0099);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("indirect d", {8'h0, d_out}, 16'h0099);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
    #1 chk("rsvd sel ptr_out", ptr_out, 16'h1234);
    tick();
    chk("rsvd sel x", x, 16'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    chk("rsvd op x", x, 16'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("x inc", x, 16'h1235);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    chk("z dec", z, 16'h0006);
    cyc(0, 3, 0, 0, 8'h11, 0, 1, 0, 0, 2);
    chk("no collision x dec", x, 16'h1234);
    cyc(27, 27, 0, 0, 8'h66, 8'h77, 0, 1, 0, 1);
    chk("word collision x", x, 16'h7766);
    for (int i = 0; i < 60; i++)
      cyc($urandom_range(31), $urandom_range(31), $urandom_range(1), $urandom_range(1),
          $urandom_range(255), $urandom_range(255), $urandom_range(1),
          ($urandom_range(3) == 0) ? 1 : 0, $urandom_range(3), $urandom_range(3));
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
